// File: rtl/item_pkg.sv
// Shared types and width helpers for the collectible item manager.
package item_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_EMERGING = 2'd1,
    SLOT_ACTIVE   = 2'd2,
    SLOT_GONE     = 2'd3
  } slot_state_t;

  function automatic int calc_off_w(input int emerge_frames);
    return $clog2(emerge_frames + 1);
  endfunction

  // A lifetime of 0 (never expires) still needs a 1-bit counter.
  function automatic int calc_life_w(input int lifetime_frames);
    return (lifetime_frames < 2) ? 1 : $clog2(lifetime_frames + 1);
  endfunction

  function automatic int calc_idx_w(input int num_items);
    return (num_items < 2) ? 1 : $clog2(num_items);
  endfunction

endpackage

// File: rtl/item_slot.sv
// One item slot: IDLE -> EMERGING -> ACTIVE -> GONE, with rise and lifetime counters.
module item_slot
  import item_pkg::*;
#(
  parameter int EMERGE_FRAMES   = 16,
  parameter int LIFETIME_FRAMES = 0,
  parameter int WARN_FRAMES     = 60,
  parameter bit INIT_ON         = 1'b0,
  localparam int OFF_W          = calc_off_w(EMERGE_FRAMES)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             spawn,
  input  logic             collision,
  output logic             on,
  output logic             emerging,
  output logic             warn,
  output logic [OFF_W-1:0] offset,
  output logic             collected,
  output slot_state_t      state_dbg
);

  localparam int LIFE_W = calc_life_w(LIFETIME_FRAMES);
  localparam logic [OFF_W-1:0]  EMERGE_INIT = OFF_W'(EMERGE_FRAMES);
  localparam logic [LIFE_W-1:0] LIFE_INIT   = LIFE_W'(LIFETIME_FRAMES);

  slot_state_t       state, state_n;
  logic [OFF_W-1:0]  ecnt, ecnt_n;
  logic [LIFE_W-1:0] lcnt, lcnt_n;
  logic              collected_n;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= INIT_ON ? SLOT_ACTIVE : SLOT_IDLE;
      ecnt      <= '0;
      lcnt      <= INIT_ON ? LIFE_INIT : '0;
      collected <= 1'b0;
    end else begin
      state     <= state_n;
      ecnt      <= ecnt_n;
      lcnt      <= lcnt_n;
      collected <= collected_n;
    end
  end

  // Collision is checked before the lifetime test so a grab on the last frame still counts.
  always_comb begin
    state_n     = state;
    ecnt_n      = ecnt;
    lcnt_n      = lcnt;
    collected_n = 1'b0;
    case (state)
      SLOT_IDLE: begin
        if (spawn) begin
          state_n = SLOT_EMERGING;
          ecnt_n  = EMERGE_INIT;
        end
      end
      SLOT_EMERGING: begin
        if (ecnt <= OFF_W'(1)) begin
          state_n = SLOT_ACTIVE;
          ecnt_n  = '0;
          lcnt_n  = LIFE_INIT;
        end else begin
          ecnt_n = ecnt - OFF_W'(1);
        end
      end
      SLOT_ACTIVE: begin
        if (collision) begin
          state_n     = SLOT_GONE;
          collected_n = 1'b1;
        end else if (LIFETIME_FRAMES != 0) begin
          if (lcnt <= LIFE_W'(1)) begin
            state_n = SLOT_GONE;
            lcnt_n  = '0;
          end else begin
            lcnt_n = lcnt - LIFE_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    on        = (state == SLOT_EMERGING) || (state == SLOT_ACTIVE);
    emerging  = (state == SLOT_EMERGING);
    offset    = emerging ? ecnt : '0;
    warn      = (state == SLOT_ACTIVE) && (LIFETIME_FRAMES != 0) &&
                (int'(lcnt) <= WARN_FRAMES);
    state_dbg = state;
  end

endmodule

// File: rtl/item_manager.sv
// Frame-rate manager for NUM_ITEMS independent power-up slots plus collect encoding.
module item_manager
  import item_pkg::*;
#(
  parameter int NUM_ITEMS       = 4,
  parameter int EMERGE_FRAMES   = 16,
  parameter int LIFETIME_FRAMES = 0,
  parameter int WARN_FRAMES     = 60,
  parameter logic [NUM_ITEMS-1:0] INIT_ACTIVE = '0,
  localparam int OFF_W = calc_off_w(EMERGE_FRAMES),
  localparam int IDX_W = calc_idx_w(NUM_ITEMS),
  localparam int CNT_W = $clog2(NUM_ITEMS + 1)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_ITEMS-1:0]       spawn,
  input  logic [NUM_ITEMS-1:0]       collision,
  output logic [NUM_ITEMS-1:0]       item_on,
  output logic [NUM_ITEMS-1:0]       item_emerging,
  output logic [NUM_ITEMS*OFF_W-1:0] emerge_offset,
  output logic [NUM_ITEMS-1:0]       item_warn,
  output logic [NUM_ITEMS-1:0]       collect_mask,
  output logic                       collect_valid,
  output logic [IDX_W-1:0]           collect_idx,
  output logic [CNT_W-1:0]           active_count,
  output logic [2*NUM_ITEMS-1:0]     state_dbg
);

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_slot
    slot_state_t slot_state;

    item_slot #(
      .EMERGE_FRAMES   (EMERGE_FRAMES),
      .LIFETIME_FRAMES (LIFETIME_FRAMES),
      .WARN_FRAMES     (WARN_FRAMES),
      .INIT_ON         (INIT_ACTIVE[g])
    ) u_slot (
      .Clk       (Clk),
      .Reset     (Reset),
      .spawn     (spawn[g]),
      .collision (collision[g]),
      .on        (item_on[g]),
      .emerging  (item_emerging[g]),
      .warn      (item_warn[g]),
      .offset    (emerge_offset[g*OFF_W +: OFF_W]),
      .collected (collect_mask[g]),
      .state_dbg (slot_state)
    );

    assign state_dbg[2*g +: 2] = slot_state;
  end

  assign collect_valid = |collect_mask;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    collect_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (collect_mask[i]) collect_idx = IDX_W'(i);
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      active_count = active_count + CNT_W'(item_on[i]);
    end
  end

endmodule

// File: tb/tb_item_manager.sv
// Bench for item_manager: timestamp-based reference model, directed scenarios, random frames.
module tb_item_manager;

  localparam int N  = 4;
  localparam int EF = 4;
  localparam int LF = 8;
  localparam int WF = 3;
  localparam int OW = 3;
  localparam int IW = 2;
  localparam int CW = 3;
  localparam logic [N-1:0] INIT = 4'b1000;

  // Model phases: 0 hidden, 1 rising, 2 live, 3 used up
  localparam int K_HIDDEN = 0;
  localparam int K_RISING = 1;
  localparam int K_LIVE   = 2;
  localparam int K_DEAD   = 3;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [N-1:0]    spawn = '0;
  logic [N-1:0]    collision = '0;
  logic [N-1:0]    item_on, item_emerging, item_warn, collect_mask;
  logic [N*OW-1:0] emerge_offset;
  logic            collect_valid;
  logic [IW-1:0]   collect_idx;
  logic [CW-1:0]   active_count;
  logic [2*N-1:0]  state_dbg;

  always #5 Clk = ~Clk;

  item_manager #(
    .NUM_ITEMS       (N),
    .EMERGE_FRAMES   (EF),
    .LIFETIME_FRAMES (LF),
    .WARN_FRAMES     (WF),
    .INIT_ACTIVE     (INIT)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .spawn         (spawn),
    .collision     (collision),
    .item_on       (item_on),
    .item_emerging (item_emerging),
    .emerge_offset (emerge_offset),
    .item_warn     (item_warn),
    .collect_mask  (collect_mask),
    .collect_valid (collect_valid),
    .collect_idx   (collect_idx),
    .active_count  (active_count),
    .state_dbg     (state_dbg)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  int           frame = 0;
  int           kind [N];
  int           t0 [N];
  logic [N-1:0] m_collect = '0;
  logic [N-1:0] init_v = INIT;
  bit           chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s frame=%0d: got %0h, expected %0h", name, frame, act, exp);
    end
  endtask

  // Phase changes derived from how long a slot has sat in its current phase.
  task automatic model_step(input logic [N-1:0] sp, input logic [N-1:0] co, input logic rst);
    frame++;
    m_collect = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        kind[i] = init_v[i] ? K_LIVE : K_HIDDEN;
        t0[i]   = frame;
      end else begin
        case (kind[i])
          K_HIDDEN: if (sp[i]) begin kind[i] = K_RISING; t0[i] = frame; end
          K_RISING: if (frame - t0[i] >= EF) begin kind[i] = K_LIVE; t0[i] = frame; end
          K_LIVE: begin
            if (co[i]) begin
              kind[i] = K_DEAD;
              m_collect[i] = 1'b1;
            end else if (LF != 0 && frame - t0[i] >= LF) begin
              kind[i] = K_DEAD;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] sp, input logic [N-1:0] co, input logic rst);
    spawn     = sp;
    collision = co;
    Reset     = rst;
    @(posedge Clk);
    model_step(sp, co, rst);
    #1;
  endtask

  always @(negedge Clk) begin
    logic [N-1:0]    e_on, e_em, e_warn;
    logic [N*OW-1:0] e_off;
    logic [2*N-1:0]  e_st;
    logic [IW-1:0]   e_idx;
    bit              found;
    if (chk_en) begin
      found = 1'b0;
      e_idx = '0;
      for (int i = 0; i < N; i++) begin
        e_on[i]   = (kind[i] == K_RISING) || (kind[i] == K_LIVE);
        e_em[i]   = (kind[i] == K_RISING);
        e_off[i*OW +: OW] = (kind[i] == K_RISING) ? OW'(EF - (frame - t0[i])) : '0;
        e_warn[i] = (kind[i] == K_LIVE) && (LF != 0) && ((LF - (frame - t0[i])) <= WF);
        e_st[2*i +: 2] = 2'(kind[i]);
        if (m_collect[i] && !found) begin
          e_idx = IW'(i);
          found = 1'b1;
        end
      end
      chk("item_on", 32'(item_on), 32'(e_on));
      chk("item_emerging", 32'(item_emerging), 32'(e_em));
      chk("emerge_offset", 32'(emerge_offset), 32'(e_off));
      chk("item_warn", 32'(item_warn), 32'(e_warn));
      chk("collect_mask", 32'(collect_mask), 32'(m_collect));
      chk("collect_valid", 32'(collect_valid), 32'(m_collect != '0));
      chk("collect_idx", 32'(collect_idx), 32'(e_idx));
      chk("active_count", 32'(active_count), 32'($countones(e_on)));
      chk("slot_state", 32'(state_dbg), 32'(e_st));
    end
  end

  initial begin
    // Reset held two frames
    tick('0, '0, 1'b1);
    chk_en = 1'b1;
    tick('0, '0, 1'b1);
    chk("rst_item_on", 32'(item_on), 32'h8);
    chk("rst_active_count", 32'(active_count), 32'd1);
    chk("rst_collect_valid", 32'(collect_valid), 32'd0);
    chk("rst_offsets", 32'(emerge_offset), 32'd0);

    // Spawn slot 0; collision while rising must be ignored
    tick(4'b0001, '0, 1'b0);
    chk("emerge_off_t1", 32'(emerge_offset[OW-1:0]), 32'd4);
    chk("emerging_t1", 32'(item_emerging[0]), 32'd1);
    tick('0, '0, 1'b0);
    chk("emerge_off_t2", 32'(emerge_offset[OW-1:0]), 32'd3);
    tick('0, 4'b0001, 1'b0);
    chk("emerge_off_t3", 32'(emerge_offset[OW-1:0]), 32'd2);
    tick('0, '0, 1'b0);
    chk("emerge_off_t4", 32'(emerge_offset[OW-1:0]), 32'd1);
    tick('0, '0, 1'b0);
    chk("active_t5_emerging", 32'(item_emerging[0]), 32'd0);
    chk("active_t5_on", 32'(item_on[0]), 32'd1);
    chk("active_t5_offset", 32'(emerge_offset[OW-1:0]), 32'd0);

    // Expiry with warn window t+10..t+12
    for (int k = 0; k < 4; k++) tick('0, '0, 1'b0);
    chk("warn_t9", 32'(item_warn[0]), 32'd0);
    tick('0, '0, 1'b0);
    chk("warn_t10", 32'(item_warn[0]), 32'd1);
    tick('0, '0, 1'b0);
    tick('0, '0, 1'b0);
    chk("warn_t12", 32'(item_warn[0]), 32'd1);
    tick('0, '0, 1'b0);
    chk("expired_t13_on", 32'(item_on[0]), 32'd0);
    chk("expired_t13_collect", 32'(collect_valid), 32'd0);

    // Simultaneous collection on slots 1 and 2
    tick(4'b0110, '0, 1'b0);
    for (int k = 0; k < 4; k++) tick('0, '0, 1'b0);
    chk("simul_live", 32'(item_on[2:1]), 32'd3);
    tick('0, 4'b0110, 1'b0);
    chk("simul_mask", 32'(collect_mask), 32'h6);
    chk("simul_valid", 32'(collect_valid), 32'd1);
    chk("simul_idx", 32'(collect_idx), 32'd1);
    tick('0, '0, 1'b0);
    chk("simul_mask_clear", 32'(collect_mask), 32'd0);

    // Collision on the last life frame of slot 3
    tick('0, '0, 1'b1);
    for (int k = 0; k < 7; k++) tick('0, '0, 1'b0);
    chk("last_frame_on", 32'(item_on[3]), 32'd1);
    chk("last_frame_warn", 32'(item_warn[3]), 32'd1);
    tick('0, 4'b1000, 1'b0);
    chk("last_frame_mask", 32'(collect_mask), 32'h8);
    chk("last_frame_idx", 32'(collect_idx), 32'd3);
    chk("last_frame_gone", 32'(item_on[3]), 32'd0);

    // Spawning into a used-up slot does nothing
    tick(4'b1000, '0, 1'b0);
    tick('0, '0, 1'b0);
    chk("gone_terminal_on", 32'(item_on[3]), 32'd0);
    chk("gone_terminal_em", 32'(item_emerging[3]), 32'd0);

    // Reset while slot 0 is rising
    tick(4'b0001, '0, 1'b0);
    tick('0, '0, 1'b0);
    tick('0, '0, 1'b1);
    chk("rst_mid_on", 32'(item_on[0]), 32'd0);
    chk("rst_mid_offset", 32'(emerge_offset[OW-1:0]), 32'd0);
    chk("rst_mid_collect", 32'(collect_valid), 32'd0);

    // Random frames with occasional resets
    for (int k = 0; k < 3000; k++) begin
      tick(4'($urandom & $urandom), 4'($urandom & $urandom), ($urandom_range(0, 99) == 0));
    end
    tick('0, '0, 1'b0);
    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/item_manager.md
Name: item_manager

Overview:
- Frame-rate manager for up to NUM_ITEMS collectible power-ups (mushrooms, flowers, stars), each with its own slot state machine.
- Lifecycle per slot: hidden → emerging from block → live on screen → consumed or expired.
- Sits between the collision detector, which drives per-item collision, and the sprite renderer / player power-up logic.
- Clk is the frame clock, so every counter counts frames.

Parameters:
- NUM_ITEMS, 4, number of independent item slots (1..16).
- EMERGE_FRAMES, 16, frames an item spends rising out of its block (≥1).
- LIFETIME_FRAMES, 0, frames an item stays live before despawning; 0 = never expires.
- WARN_FRAMES, 60, remaining-life threshold at or below which item_warn asserts (ignored when LIFETIME_FRAMES=0).
- INIT_ACTIVE, '0, NUM_ITEMS-bit mask; slots whose bit is set leave reset directly in ACTIVE.

Ports:
- Clk  in  1  frame clock
- Reset  in  1  synchronous, active-high reset
- spawn  in  NUM_ITEMS  per-slot block-bump trigger, sampled each frame
- collision  in  NUM_ITEMS  per-slot player/item overlap, sampled each frame
- item_on  out  NUM_ITEMS  slot visible (EMERGING or ACTIVE)
- item_emerging  out  NUM_ITEMS  slot in EMERGING
- emerge_offset  out  NUM_ITEMS*OFF_W  per-slot rise offset in frames (slot i at bits [i*OFF_W +: OFF_W]); OFF_W=$clog2(EMERGE_FRAMES+1)
- item_warn  out  NUM_ITEMS  slot ACTIVE with remaining life ≤ WARN_FRAMES (renderer blinks sprite)
- collect_mask  out  NUM_ITEMS  one-frame pulse, slot collected this frame
- collect_valid  out  1  OR of collect_mask
- collect_idx  out  $clog2(NUM_ITEMS) (min 1)  lowest set index of collect_mask; 0 when none
- active_count  out  $clog2(NUM_ITEMS+1)  number of slots in EMERGING or ACTIVE

Behaviour:
- Per-slot states: IDLE, EMERGING, ACTIVE, GONE. Each slot has registers state, ecnt (OFF_W bits) and lcnt (lifetime width, min 1 bit).
- Reset:
  - Slot with INIT_ACTIVE bit=1: ACTIVE, lcnt=LIFETIME_FRAMES.
  - Other slots: IDLE, ecnt=0, lcnt=0.
  - collect_mask cleared.
  - A Reset mid-emerge or mid-life discards all progress; no collect pulse is produced.
- IDLE:
  - spawn[i]=1 → EMERGING next frame, ecnt=EMERGE_FRAMES.
  - collision is ignored.
- EMERGING:
  - ecnt decrements each frame.
  - When ecnt==1 → ACTIVE next frame, ecnt=0, lcnt=LIFETIME_FRAMES. EMERGING therefore lasts exactly EMERGE_FRAMES frames.
  - collision and spawn are ignored; an item cannot be collected while rising.
- ACTIVE:
  - collision[i]=1 → GONE next frame, and collect_mask[i]=1 in that same next frame (registered, 1-frame latency).
  - Otherwise, if LIFETIME_FRAMES≠0, lcnt decrements; when lcnt==1 → GONE with no collect pulse.
  - Collision and final lifetime frame together: collision wins, collect pulse issued.
  - spawn is ignored.
- GONE: terminal until Reset; all inputs ignored. Matches single-use "?" block semantics.
- Output decoding:
  - emerge_offset[i] = ecnt in EMERGING, else 0. It counts EMERGE_FRAMES down to 1; the renderer shifts the sprite up by (EMERGE_FRAMES − offset)·step.
  - item_on, item_emerging, item_warn and active_count decode combinationally from the registered state and counters.
  - item_warn = ACTIVE && LIFETIME_FRAMES≠0 && lcnt≤WARN_FRAMES.
- Simultaneous collections across slots: all set in collect_mask the same frame; collect_idx reports the lowest index.
- Slots are fully independent; no shared resources and no arbitration except collect_idx encoding.
- No arithmetic wrap: counters never decrement below 1 in their live state.

Decomposition:
- Package item_pkg: slot_state_t enum (IDLE, EMERGING, ACTIVE, GONE), localparam helpers for OFF_W and LIFE_W.
- Sub-module item_slot: one slot FSM plus its counters, parameterised by EMERGE_FRAMES, LIFETIME_FRAMES, WARN_FRAMES, INIT_ON. Outputs: on, emerging, warn, offset, collected pulse.
- item_manager: generate-loops NUM_ITEMS item_slot instances, then adds the lowest-index priority encoder and the population count.

Test Plan (NUM_ITEMS=4, EMERGE_FRAMES=4, LIFETIME_FRAMES=8, WARN_FRAMES=3, INIT_ACTIVE=4'b1000):
- Reset:
  - Stimulus: Reset held 2 frames, then released.
  - Required: item_on=4'b1000, active_count=1, collect_valid=0, all emerge_offset=0.
- Spawn and emerge:
  - Stimulus: spawn[0] pulsed at frame t.
  - Required: item_emerging[0]=1 frames t+1..t+4 with offset 4,3,2,1; ACTIVE at t+5; collision[0] during t+2 ignored.
- Expiry:
  - Stimulus: slot 0 ACTIVE from t+5 with no collision.
  - Required: item_warn[0]=1 frames t+10..t+12; item_on[0]=0 at t+13; no collect pulse.
- Simultaneous collection:
  - Stimulus: slots 1 and 2 ACTIVE, collision=4'b0110 for one frame.
  - Required: next frame collect_mask=4'b0110, collect_valid=1, collect_idx=1; following frame collect_mask=0.
- Collision on last life frame:
  - Stimulus: collision on the frame lcnt==1.
  - Required: GONE with collect_mask pulse set (collision wins).
- GONE is terminal; Reset mid-emerge:
  - Stimulus: spawn into a GONE slot.
  - Required: no effect.
  - Stimulus: Reset while slot 0 is mid-emerge.
  - Required: slot 0 IDLE next frame, offset 0, no collect pulse.
